// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: state enum, IF/ID payload and default reset/NOP values.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush (NOP insert), load, bubble-clear and hold controls.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   load,
  input  logic   clear,
  input  if_id_t d,
  output logic   valid,
  output if_id_t q
);

  // Priority: flush > load > clear > hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid      <= 1'b0;
      q.instr    <= NOP_INSTR;
      q.pc       <= '0;
      q.pc_plus4 <= '0;
    end else if (flush) begin
      valid   <= 1'b0;
      q.instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: pc register, BOOT/RUN/HALTED control and IF/ID register.
// Optional performance counters enabled with FETCH_PERF_CNT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, pc_plus4_c, pc_next_c;
  logic            fire_c, flush_c, clear_c;
  if_id_t          if_id_d, if_id_q;
  logic            unused_redirect_bits;

  assign pc_plus4_c           = pc + 32'(4);
  assign unused_redirect_bits = ^redirect_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_next;
  end

  // Next state plus fetch controls; redirect outranks everything outside BOOT.
  always_comb begin
    state_next = state;
    fire_c     = 1'b0;
    flush_c    = 1'b0;
    clear_c    = 1'b0;
    pc_next_c  = pc;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (redirect_valid) begin
          flush_c   = 1'b1;
          pc_next_c = align_pc(redirect_pc);
        end else begin
          if (halt) state_next = HALTED;
          fire_c = !stall && (!id_valid || id_ready);
          if (fire_c) pc_next_c = pc_plus4_c;
        end
      end
      HALTED: begin
        if (redirect_valid) begin
          state_next = RUN;
          flush_c    = 1'b1;
          pc_next_c  = align_pc(redirect_pc);
        end
      end
      default: state_next = BOOT;
    endcase
    clear_c = !fire_c && !flush_c && id_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= align_pc(RESET_PC);
    else     pc <= pc_next_c;
  end

  assign imem_pc          = pc;
  assign if_id_d.instr    = imem_instr;
  assign if_id_d.pc       = pc;
  assign if_id_d.pc_plus4 = pc_plus4_c;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_c),
    .load  (fire_c),
    .clear (clear_c),
    .d     (if_id_d),
    .valid (id_valid),
    .q     (if_id_q)
  );

  assign id_instr    = if_id_q.instr;
  assign id_pc       = if_id_q.pc;
  assign id_pc_plus4 = if_id_q.pc_plus4;

`ifdef FETCH_PERF_CNT_EN
  // Free-running wrap-around counters for fetches and stalled RUN cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (fire_c)                  fetch_count <= fetch_count + 32'(1);
      if (state == RUN && stall)   stall_count <= stall_count + 32'(1);
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, value loaded into id_instr on flush/reset.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_pc  output  32  fetch address to instruction memory, equal to pc register.
REQ-006 SHALL have port imem_instr  input  32  instruction returned combinationally for imem_pc in the same cycle.
REQ-007 SHALL have port stall  input  1  hazard stall from decode; freezes pc.
REQ-008 SHALL have port redirect_valid  input  1  taken branch/jump from execute.
REQ-009 SHALL have port redirect_pc  input  32  branch/jump target.
REQ-010 SHALL have port halt  input  1  stop fetching.
REQ-011 SHALL have port id_ready  input  1  decode accepts IF/ID contents this cycle.
REQ-012 SHALL have ports id_valid (1), id_instr (32), id_pc (32), id_pc_plus4 (32), all outputs forming the IF/ID register.

Function
REQ-013 SHALL implement FSM states BOOT, RUN, HALTED; reset enters BOOT.
REQ-014 SHALL leave BOOT for RUN after exactly one clock with no fetch (memory settle cycle).
REQ-015 SHALL move RUN->HALTED when halt=1 and no redirect; HALTED->RUN only on redirect_valid=1; halt ignored in BOOT.
REQ-016 SHALL define fire = (state==RUN) && !stall && !redirect_valid && (!id_valid || id_ready).
REQ-017 SHALL on fire load id_instr<=imem_instr, id_pc<=pc, id_pc_plus4<=pc+4, id_valid<=1, pc<=pc+4 (latency: one cycle pc->IF/ID).
REQ-018 SHALL compute pc+4 modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0).
REQ-019 SHALL when id_valid=1, id_ready=0 and no redirect, hold pc and all IF/ID outputs unchanged.
REQ-020 SHALL when no fire, no redirect and id_ready=1, clear id_valid (bubble) and hold pc.
REQ-021 SHALL give redirect_valid top priority in RUN and HALTED: pc<={redirect_pc[31:2],2'b00}, id_valid<=0, id_instr<=NOP_INSTR, regardless of stall, halt, id_ready.
REQ-022 SHALL ignore redirect_valid in BOOT.
REQ-023 SHALL keep pc bits [1:0] always 2'b00.
REQ-024 SHALL in HALTED hold pc, perform no fire, and clear id_valid once id_ready=1.

Reset
REQ-025 SHALL asynchronously on rst=1 set pc=RESET_PC, state=BOOT, id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=0, and counters to 0.
REQ-026 SHALL discard any in-flight IF/ID contents on reset mid-operation; first post-reset fetch is RESET_PC on the second rising edge after rst deasserts.

Configuration
REQ-027 SHALL with FETCH_PERF_CNT_EN defined add outputs fetch_count (32) incremented on each fire and stall_count (32) incremented each RUN cycle with stall=1; both wrap at 2^32.
REQ-028 SHALL without FETCH_PERF_CNT_EN omit those ports and counters entirely; all other behaviour identical.

Structure
REQ-029 SHALL place the fetch state enum, default RESET_PC and NOP_INSTR constants in shared package fetch_pkg.
REQ-030 SHALL implement the IF/ID register (valid, instr, pc, pc_plus4 with load/clear/hold controls) as sub-module if_id_reg.

Verification
REQ-031 SHALL cover reset release, id_ready=1: imem_pc 0x0 for two cycles, then 0x4, 0x8; id_valid first high two edges after release with id_pc=0x0.
REQ-032 SHALL cover stall=1 for 3 cycles at pc=0x10 with id_ready=1: imem_pc stays 0x10, id_valid=0 for those cycles, fetch resumes at 0x10.
REQ-033 SHALL cover id_ready=0 with id_valid=1 for 2 cycles: id_instr/id_pc/imem_pc unchanged.
REQ-034 SHALL cover redirect_valid=1, redirect_pc=0x0000_0103 while stall=1: next imem_pc=0x100, id_valid=0, id_instr=NOP_INSTR.
REQ-035 SHALL cover pc=0xFFFF_FFFC fire: id_pc_plus4=0x0, next imem_pc=0x0; and halt=1 then redirect to 0x40: HALTED holds pc, redirect resumes RUN at 0x40.
REQ-036 SHALL with FETCH_PERF_CNT_EN cover 5 fires and 2 stall cycles: fetch_count=5, stall_count=2; rst mid-run clears both to 0.
